// File: rtl/peripheral_apb4_sram.sv
// APB4 completer backed by a byte-strobed word memory.
// Supports configurable wait states and error responses (range, alignment, privilege).
module peripheral_apb4_sram #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 0,
    parameter int PRIV_ONLY   = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [2:0]              PPROT,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0]     LSB_MASK = ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [ADDR_WIDTH-LSB-1:0] DEPTH_W  = (ADDR_WIDTH - LSB)'(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    err_q;
    logic                    write_q;
    logic [IW-1:0]           idx_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    setup;
    logic                    err_d;
    logic [IW-1:0]           idx_d;
    logic                    commit;
    logic                    unused_pprot;

    assign unused_pprot = ^PPROT[2:1];

    assign setup  = (state_q == IDLE) && PSEL && !PENABLE;
    assign err_d  = (PADDR[ADDR_WIDTH-1:LSB] >= DEPTH_W)
                  || ((PADDR & LSB_MASK) != '0)
                  || ((PRIV_ONLY != 0) && !PPROT[0]);
    assign idx_d  = PADDR[LSB +: IW];

    // Completion needs the access phase still asserted; a dropped PSEL aborts silently.
    assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0) && PSEL && PENABLE;
    assign PSLVERR = PREADY && err_q;
    assign commit  = PREADY && write_q && !err_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            PRDATA  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        state_q <= ACCESS;
                        cnt_q   <= 4'(WAIT_STATES);
                        err_q   <= err_d;
                        write_q <= PWRITE;
                        idx_q   <= idx_d;
                        PRDATA  <= (!PWRITE && !err_d) ? mem[idx_d] : '0;
                    end else begin
                        PRDATA  <= '0;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state_q <= IDLE;
                    end else if (PENABLE) begin
                        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                        else               state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory is not reset; reset in the completion cycle still drops the write.
    always_ff @(posedge PCLK) begin
        if (!PRESET && commit) begin
            for (int i = 0; i < NB; i++) begin
                if (PSTRB[i]) mem[idx_q][i*8 +: 8] <= PWDATA[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_peripheral_apb4_sram.sv
// Bench for peripheral_apb4_sram: three configurations on a shared APB bus
// (WS=0; WS=3; WS=2 with PRIV_ONLY), checked against an array-based memory model.
module tb_peripheral_apb4_sram;
    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     paddr, pwdata;
    logic [2:0]      pprot;
    logic [2:0]      psel;
    logic            penable, pwrite;
    logic [3:0]      pstrb;
    logic [2:0][31:0] prdata;
    logic [2:0]      pready, pslverr;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] ref_mem [3][128];
    int          ws [3] = '{0, 3, 2};

    always #5 clk = ~clk;

    peripheral_apb4_sram #(.WAIT_STATES(0), .PRIV_ONLY(0)) u_d0 (
        .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PPROT(pprot), .PSEL(psel[0]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
    peripheral_apb4_sram #(.WAIT_STATES(3), .PRIV_ONLY(0)) u_d1 (
        .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PPROT(pprot), .PSEL(psel[1]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
    peripheral_apb4_sram #(.WAIT_STATES(2), .PRIV_ONLY(1)) u_d2 (
        .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PPROT(pprot), .PSEL(psel[2]),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    // Reference model: word array per configuration, error rules from the address map.
    function automatic logic m_err(int d, logic [31:0] a, logic [2:0] p);
        return (a >= 32'd512) || (a % 4 != 0) || (d == 2 && p[0] == 1'b0);
    endfunction

    function automatic logic [31:0] m_read(int d, logic [31:0] a, logic [2:0] p);
        if (m_err(d, a, p)) return 32'h0;
        return ref_mem[d][a / 4];
    endfunction

    function automatic void m_write(int d, logic [31:0] a, logic [31:0] w, logic [3:0] s, logic [2:0] p);
        logic [31:0] cur;
        if (m_err(d, a, p)) return;
        cur = ref_mem[d][a / 4];
        for (int b = 0; b < 4; b++) if (s[b]) cur[b*8 +: 8] = w[b*8 +: 8];
        ref_mem[d][a / 4] = cur;
    endfunction

    // One APB transfer; caller is just past a rising edge. Leaves bus idle past the completion edge.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rd, output logic er, output int waits);
        psel = 3'b000; psel[d] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = w; pstrb = s; pprot = p;
        @(posedge clk); #1 penable = 1'b1;
        waits = 0; rd = '0; er = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (pready[d]) break;
            waits++;
        end
        if (!pready[d]) waits = -1;
        rd = prdata[d]; er = pslverr[d];
        @(posedge clk); #1 psel = 3'b000; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if ({pready, pslverr, prdata} !== '0)
                $display("FAIL reset_idle cyc %0d: rdy=%b err=%b rdata=%h, want all 0", i, pready, pslverr, prdata);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_init();
        logic [31:0] rd; logic er; int wt; logic [31:0] w;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 128; i++) begin
                w = $urandom;
                xfer(d, 1'b1, i * 4, w, 4'hF, 3'b001, rd, er, wt);
                m_write(d, i * 4, w, 4'hF, 3'b001);
            end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int wt;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, wt);
        m_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001);
        n_chk++; if (wt !== 0 || er !== 1'b0) $display("FAIL wr_full: waits=%0d err=%b, want 0/0", wt, er); else n_pass++;
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL rd_full: got %h err=%b, want deadbeef/0", rd, er); else n_pass++;
        xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 3'b001, rd, er, wt);
        m_write(0, 32'h10, 32'h11223344, 4'b0101, 3'b001);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 3'b001, rd, er, wt);
        n_chk++; if (rd !== 32'hDE22BE44) $display("FAIL rd_partial: got %h, want de22be44", rd); else n_pass++;
        // PRDATA held through the cycle after completion, then cleared.
        n_chk++; if (prdata[0] !== 32'hDE22BE44) $display("FAIL rdata_hold: got %h, want de22be44", prdata[0]); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (prdata[0] !== 32'h0) $display("FAIL rdata_clear: got %h, want 0", prdata[0]); else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int wt; logic [31:0] w;
        w = $urandom;
        xfer(1, 1'b1, 32'h04, w, 4'hF, 3'b001, rd, er, wt);
        m_write(1, 32'h04, w, 4'hF, 3'b001);
        n_chk++; if (wt !== 3) $display("FAIL ws_write: waits=%0d, want 3", wt); else n_pass++;
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (wt !== 3 || rd !== w) $display("FAIL ws_read: waits=%0d data=%h, want 3/%h", wt, rd, w); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int wt; logic [31:0] exp;
        xfer(0, 1'b1, 32'h200, 32'hA5A5A5A5, 4'hF, 3'b001, rd, er, wt);
        n_chk++; if (er !== 1'b1 || wt !== 0) $display("FAIL err_range_wr: err=%b waits=%0d, want 1/0", er, wt); else n_pass++;
        exp = m_read(0, 32'h0, 3'b001);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (rd !== exp) $display("FAIL err_range_nochg: got %h, want %h", rd, exp); else n_pass++;
        xfer(0, 1'b0, 32'h202, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_misal_rd: err=%b data=%h, want 1/0", er, rd); else n_pass++;
        xfer(0, 1'b1, 32'h12, 32'h5A5A5A5A, 4'hF, 3'b001, rd, er, wt);
        exp = m_read(0, 32'h10, 3'b001);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (rd !== exp) $display("FAIL err_misal_nochg: got %h, want %h", rd, exp); else n_pass++;
        xfer(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (er !== 1'b0) $display("FAIL strb0_err: err=%b, want 0", er); else n_pass++;
        exp = m_read(0, 32'h14, 3'b001);
        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (rd !== exp) $display("FAIL strb0_nochg: got %h, want %h", rd, exp); else n_pass++;
        xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, wt);
        n_chk++; if (er !== 1'b1 || rd !== 32'h0 || wt !== 2) $display("FAIL err_priv: err=%b data=%h waits=%0d, want 1/0/2", er, rd, wt); else n_pass++;
        exp = m_read(2, 32'h08, 3'b001);
        xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (er !== 1'b0 || rd !== exp) $display("FAIL priv_ok: err=%b data=%h, want 0/%h", er, rd, exp); else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int wt; logic [31:0] exp;
        exp = m_read(2, 32'h20, 3'b001);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
        pwdata = ~exp; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        n_chk++; if (pready[2] !== 1'b0) $display("FAIL abort_rdy_a: pready=%b, want 0", pready[2]); else n_pass++;
        @(posedge clk); #1 psel = 3'b000;
        @(negedge clk);
        n_chk++; if (pready[2] !== 1'b0) $display("FAIL abort_rdy_b: pready=%b, want 0", pready[2]); else n_pass++;
        @(posedge clk); #1 penable = 1'b0;
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (rd !== exp) $display("FAIL abort_nochg: got %h, want %h", rd, exp); else n_pass++;
    endtask

    task automatic test_penable_idle();
        logic [31:0] rd; logic er; int wt; logic [31:0] exp;
        exp = m_read(0, 32'h30, 3'b001);
        psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h30; pwdata = ~exp; pstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (pready[0] !== 1'b0) $display("FAIL penable_idle cyc %0d: pready=%b, want 0", i, pready[0]); else n_pass++;
        end
        @(posedge clk); #1 psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (rd !== exp) $display("FAIL penable_idle_nochg: got %h, want %h", rd, exp); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int wt; logic [31:0] exp;
        exp = m_read(1, 32'h08, 3'b001);
        // Read, reset during second access cycle: loaded PRDATA must clear.
        psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h08; pstrb = 4'h0; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if ({pready[1], pslverr[1], prdata[1]} !== '0) $display("FAIL rst_mid_rd: rdy=%b err=%b data=%h, want 0", pready[1], pslverr[1], prdata[1]); else n_pass++;
        rst = 1'b0; psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        // Write, reset lands on the completion edge: write must be dropped.
        psel = 3'b010; pwrite = 1'b1; pwdata = ~exp; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if ({pready[1], pslverr[1], prdata[1]} !== '0) $display("FAIL rst_mid_wr: rdy=%b err=%b data=%h, want 0", pready[1], pslverr[1], prdata[1]); else n_pass++;
        rst = 1'b0; psel = 3'b000; penable = 1'b0;
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, wt);
        n_chk++; if (rd !== exp) $display("FAIL rst_mid_nochg: got %h, want %h", rd, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int wt; logic [31:0] a, w; logic [3:0] s;
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(0, 127) * 4; w = $urandom; s = 4'($urandom_range(1, 15));
            xfer(0, 1'b1, a, w, s, 3'b001, rd, er, wt);
            m_write(0, a, w, s, 3'b001);
            xfer(0, 1'b0, a, 32'h0, 4'h0, 3'b001, rd, er, wt);
            n_chk++; if (rd !== m_read(0, a, 3'b001)) $display("FAIL b2b_raw %0d @%h: got %h, want %h", i, a, rd, m_read(0, a, 3'b001)); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int wt; logic [31:0] a, w, exp; logic [3:0] s; logic [2:0] p; logic wr; int d;
        for (int i = 0; i < 150; i++) begin
            d = $urandom_range(0, 2);
            a = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 127) * 4 : $urandom_range(0, 1023);
            w = $urandom; s = 4'($urandom); wr = 1'($urandom);
            p = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'b001;
            exp = m_read(d, a, p);
            xfer(d, wr, a, w, s, p, rd, er, wt);
            n_chk++; if (er !== m_err(d, a, p) || wt !== ws[d]) $display("FAIL rnd_resp %0d d%0d @%h: err=%b waits=%0d, want %b/%0d", i, d, a, er, wt, m_err(d, a, p), ws[d]); else n_pass++;
            if (!wr) begin
                n_chk++; if (rd !== exp) $display("FAIL rnd_read %0d d%0d @%h: got %h, want %h", i, d, a, rd, exp); else n_pass++;
            end else m_write(d, a, w, s, p);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_wait_states();
        test_errors();
        test_abort();
        test_penable_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
